mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side end of the core's unified memory bus: the responder for mem_command/mem_addr/mem_data
//  and the source of mem2proc_response/mem2proc_data/mem2proc_tag.
//  Tagged, fixed-latency, pipelined 64-bit main memory; accepts at most one BUS_LOAD/BUS_STORE per cycle.
//  Serves both the icache and dcache through the core's top-level bus mux; used as the bench and FPGA memory model.
// PARAMETERS
//  LATENCY    4     cycles from command cycle to data/tag return cycle (>=1)
//  NUM_LINES  8192  64-bit lines in the array (power of 2; 64 KiB default)
//  NUM_TAGS   16    tag space; tag 0 = "not accepted", so 1..NUM_TAGS-1 are usable
// PORTS
//  clock                input   1   clock
//  reset                input   1   synchronous, active-high
//  proc2mem_command     input   2   BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2 (3 treated as BUS_NONE)
//  proc2mem_addr        input   32  byte address; bits[2:0] ignored
//  proc2mem_data        input   64  store data
//  mem2proc_response    output  4   tag granted this cycle (combinational); 0 = refused
//  mem2proc_data        output  64  load data; valid only while mem2proc_tag!=0
//  mem2proc_tag         output  4   tag of the load completing this cycle; 0 = none
// BEHAVIOUR
//  - Index = proc2mem_addr[$clog2(NUM_LINES)+2:3]; upper bits ignored (aliasing wraps).
//  - Free-tag bitmap (registered); grant = lowest-numbered free tag. mem2proc_response is a function of
//    command + bitmap only and is nonzero in the same cycle as a LOAD/STORE iff a tag is free.
//  - LOAD accepted in cycle c: array read at the c edge into the return pipeline; mem2proc_tag/data show
//    (tag, line) during cycle c+LATENCY for exactly one cycle; the tag is freed at the end of c+LATENCY
//    and is grantable from c+LATENCY+1.
//  - STORE accepted in cycle c: full 64-bit write at the c edge; tag is granted but never broadcast and
//    is freed at the same edge (grantable in c+1). A load accepted in c+1 to the same line sees the new data.
//  - Refused command (response 0): no array access, no state change; the requester retries.
//  - Simultaneous accept and return in one cycle: both happen; the freed and the newly granted tag
//    are never the same tag in that cycle.
//  - Return pipeline: LATENCY-deep shift of {valid,tag,data}; one return max per cycle, in order.
//  - Outputs when idle: mem2proc_tag=0, mem2proc_data=64'h0.
//  - Reset: bitmap all free, pipeline valids cleared, response=0 during reset, tag/data outputs 0 the
//    cycle after reset. In-flight loads are dropped silently. The array is NOT reset (contents retained).
// CONFIGURATION
//  MEM_RESPONDER_RANDOM_STALL_EN defined: 8-bit Fibonacci LFSR (taps 8,6,5,4), reset to 8'hA5, steps
//    every cycle; when lfsr[1:0]==2'b00 any LOAD/STORE that cycle is refused (response 0). This exercises
//    retry paths in icache/dcache/MSHRs.
//  Undefined: no LFSR; refusal occurs only on tag exhaustion.
// STRUCTURE
//  - Shared package (sys_defs): BUS_COMMAND enum, MEM_TAG_W=4, MEM_LINE_T (64-bit), MEM_NUM_TAGS.
//  - Sub-module mem_rsp_tag_alloc: free bitmap, lowest-free priority encoder, alloc/free ports
//    (alloc and free in the same cycle are legal).
//  - Top: array, return pipeline, command decode, optional LFSR.
// TESTING
//  1 STORE 64'hDEADBEEF_CAFEF00D @0x100 (c0), LOAD @0x100 (c1) -> response 1 in c1; tag 1 plus that data
//    in c1+4; mem2proc_tag=0 in every other cycle.
//  2 LOADs in four back-to-back cycles @0x0,0x8,0x10,0x18 -> responses 1,2,3,4; returns in consecutive
//    cycles 4..7, same order, correct data.
//  3 LATENCY=20: 16 back-to-back LOADs -> responses 1..15, then 0 on the 16th. After tag 1 returns, the
//    next LOAD is granted tag 1.
//  4 Reset asserted with 3 loads in flight -> no tag ever returns. The first post-reset LOAD gets tag 1;
//    preloaded array data is intact.
//  5 LOAD @0x107 vs @0x100 -> identical data (bits[2:0] ignored). Addr 0x10100 aliases 0x100 at 64 KiB.
//  6 With MEM_RESPONDER_RANDOM_STALL_EN: 64 consecutive LOAD attempts -> refusal pattern matches the
//    reference LFSR from 8'hA5. Every granted load returns exactly once.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared bus definitions for the unified memory bus: command encoding, tag width, line type.
package mem_responder_pkg;

    localparam int unsigned MEM_TAG_W    = 4;
    localparam int unsigned MEM_NUM_TAGS = 16;

    typedef logic [63:0]          mem_line_t;
    typedef logic [MEM_TAG_W-1:0] mem_tag_t;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_command_e;

    // Encoding 3 is reserved and behaves as an idle cycle.
    function automatic bus_command_e decode_command(input logic [1:0] raw);
        unique case (raw)
            2'd1:    return BUS_LOAD;
            2'd2:    return BUS_STORE;
            default: return BUS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Unified memory bus between the core (master) and main memory (slave).
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    mem_line_t   proc2mem_data;
    mem_tag_t    mem2proc_response;
    mem_line_t   mem2proc_data;
    mem_tag_t    mem2proc_tag;

    modport master (
        output proc2mem_command,
        output proc2mem_addr,
        output proc2mem_data,
        input  mem2proc_response,
        input  mem2proc_data,
        input  mem2proc_tag
    );

    modport slave (
        input  proc2mem_command,
        input  proc2mem_addr,
        input  proc2mem_data,
        output mem2proc_response,
        output mem2proc_data,
        output mem2proc_tag
    );

endinterface

// File: rtl/mem_rsp_tag_alloc.sv
// Free-tag bitmap with lowest-free grant; tag 0 is never handed out (it means "refused").
module mem_rsp_tag_alloc
    import mem_responder_pkg::*;
#(
    parameter int unsigned NUM_TAGS = MEM_NUM_TAGS
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     i_alloc,
    input  logic     i_free,
    input  mem_tag_t i_free_tag,
    output mem_tag_t o_grant
);

    logic [NUM_TAGS-1:0] r_free;
    logic [NUM_TAGS-1:0] w_free_d;
    mem_tag_t            w_grant;

    always_comb begin
        w_grant = '0;
        for (int i = int'(NUM_TAGS) - 1; i >= 1; i--) begin
            if (r_free[i]) begin
                w_grant = mem_tag_t'(i);
            end
        end
    end

    // The freed tag is busy this cycle, so it can never collide with the grant.
    always_comb begin
        w_free_d = r_free;
        if (i_alloc && (w_grant != '0)) begin
            w_free_d[w_grant] = 1'b0;
        end
        if (i_free) begin
            w_free_d[i_free_tag] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_free <= {{(NUM_TAGS-1){1'b1}}, 1'b0};
        end else begin
            r_free <= w_free_d;
        end
    end

    assign o_grant = w_grant;

endmodule

// File: rtl/mem_responder.sv
// Tagged fixed-latency pipelined 64-bit main memory. Define MEM_RESPONDER_RANDOM_STALL_EN to
// add LFSR-driven random refusals that exercise requester retry paths.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned LATENCY   = 4,
    parameter int unsigned NUM_LINES = 8192,
    parameter int unsigned NUM_TAGS  = MEM_NUM_TAGS
) (
    input logic            clock,
    input logic            reset,
    mem_responder_if.slave mem_bus
);

    localparam int unsigned IDX_W = $clog2(NUM_LINES);

    typedef struct packed {
        logic      valid;
        mem_tag_t  tag;
        mem_line_t data;
    } ret_t;

    mem_line_t    r_mem [NUM_LINES];
    ret_t         r_pipe [LATENCY];
    ret_t         w_pipe_in;
    bus_command_e w_cmd;
    logic [IDX_W-1:0] w_index;
    mem_tag_t     w_grant;
    logic         w_stall;
    logic         w_req;
    logic         w_accept;
    logic         w_load_acc;
    logic         w_store_acc;
    logic         w_unused_addr;

    assign w_cmd         = decode_command(mem_bus.proc2mem_command);
    assign w_index       = mem_bus.proc2mem_addr[IDX_W+2:3];
    assign w_unused_addr = ^{mem_bus.proc2mem_addr[31:IDX_W+3], mem_bus.proc2mem_addr[2:0]};

`ifdef MEM_RESPONDER_RANDOM_STALL_EN
    logic [7:0] r_lfsr;

    // Fibonacci LFSR, taps 8,6,5,4.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    assign w_req       = (w_cmd != BUS_NONE) && !w_stall && !reset;
    assign w_accept    = w_req && (w_grant != '0);
    assign w_load_acc  = w_accept && (w_cmd == BUS_LOAD);
    assign w_store_acc = w_accept && (w_cmd == BUS_STORE);

    assign mem_bus.mem2proc_response = w_accept ? w_grant : '0;

    // Stores never occupy a tag past their own cycle, so only loads allocate.
    mem_rsp_tag_alloc #(
        .NUM_TAGS (NUM_TAGS)
    ) u_tag_alloc (
        .clock      (clock),
        .reset      (reset),
        .i_alloc    (w_load_acc),
        .i_free     (r_pipe[LATENCY-1].valid),
        .i_free_tag (r_pipe[LATENCY-1].tag),
        .o_grant    (w_grant)
    );

    always_ff @(posedge clock) begin
        if (w_store_acc) begin
            r_mem[w_index] <= mem_bus.proc2mem_data;
        end
    end

    // Idle slots carry zeros so the outputs read 0 without extra muxing.
    always_comb begin
        w_pipe_in       = '0;
        w_pipe_in.valid = w_load_acc;
        if (w_load_acc) begin
            w_pipe_in.tag  = w_grant;
            w_pipe_in.data = r_mem[w_index];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_pipe_in;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign mem_bus.mem2proc_tag  = r_pipe[LATENCY-1].tag;
    assign mem_bus.mem2proc_data = r_pipe[LATENCY-1].data;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: vector table plus hand-written multi-cycle cases.
module tb_mem_responder;

    localparam logic [1:0] C_NO = 2'd0;
    localparam logic [1:0] C_LD = 2'd1;
    localparam logic [1:0] C_ST = 2'd2;

    localparam logic [63:0] DA = 64'hDEADBEEF_CAFEF00D;
    localparam logic [63:0] D0 = 64'h1111_0000_0000_0001;
    localparam logic [63:0] D1 = 64'h2222_0000_0000_0002;
    localparam logic [63:0] D2 = 64'h3333_0000_0000_0003;
    localparam logic [63:0] D3 = 64'h4444_0000_0000_0004;
    localparam logic [63:0] DN = 64'hABCD_EF01_2345_6789;

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [3:0]  resp;
        logic [3:0]  tag;
        logic [63:0] data;
    } vec_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    int   cyc;

    logic [3:0]  s_resp;
    logic [3:0]  s_tag;
    logic [63:0] s_data;

    mem_responder_if bus ();
    mem_responder_if bus20 ();

    mem_responder #(.LATENCY(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .mem_bus (bus)
    );

    mem_responder #(.LATENCY(20)) dut20 (
        .clock   (clock),
        .reset   (reset),
        .mem_bus (bus20)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    // One bus cycle: drive just after the edge, sample the selected DUT mid-cycle.
    task automatic step(input logic rst_v, input bit sel20, input logic [1:0] cmd,
                        input logic [31:0] addr, input logic [63:0] wdata);
        @(posedge clock);
        #1;
        reset = rst_v;
        bus.proc2mem_command   = sel20 ? C_NO : cmd;
        bus.proc2mem_addr      = addr;
        bus.proc2mem_data      = wdata;
        bus20.proc2mem_command = sel20 ? cmd : C_NO;
        bus20.proc2mem_addr    = addr;
        bus20.proc2mem_data    = wdata;
        #1;
        s_resp = sel20 ? bus20.mem2proc_response : bus.mem2proc_response;
        s_tag  = sel20 ? bus20.mem2proc_tag : bus.mem2proc_tag;
        s_data = sel20 ? bus20.mem2proc_data : bus.mem2proc_data;
        cyc++;
    endtask

    vec_t vecs [33];

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        reset  = 1'b1;
        bus.proc2mem_command   = C_NO;
        bus.proc2mem_addr      = '0;
        bus.proc2mem_data      = '0;
        bus20.proc2mem_command = C_NO;
        bus20.proc2mem_addr    = '0;
        bus20.proc2mem_data    = '0;

        // Requests during reset are refused.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, C_LD, 32'h100, '0);
            chk("reset_resp", 64'(s_resp), 64'd0);
        end

`ifdef MEM_RESPONDER_RANDOM_STALL_EN
        begin
            logic [7:0]  lfsr;
            logic [15:0] free_m;
            logic [3:0]  due [80];
            logic [3:0]  g;
            logic [3:0]  exp_resp;
            int          grants;
            int          returns;
            lfsr    = 8'hA5;
            free_m  = 16'hFFFE;
            grants  = 0;
            returns = 0;
            for (int i = 0; i < 80; i++) due[i] = '0;
            for (int i = 0; i < 72; i++) begin
                g = '0;
                for (int t = 15; t >= 1; t--) if (free_m[t]) g = 4'(t);
                exp_resp = (i < 64 && lfsr[1:0] != 2'b00) ? g : 4'd0;
                step(1'b0, 1'b0, (i < 64) ? C_LD : C_NO, 32'(i * 8), '0);
                chk("stall_resp", 64'(s_resp), 64'(exp_resp));
                chk("stall_tag", 64'(s_tag), 64'(due[i]));
                if (s_tag != '0) returns++;
                if (exp_resp != '0) begin
                    grants++;
                    free_m[exp_resp] = 1'b0;
                    due[i+4] = exp_resp;
                end
                if (due[i] != '0) free_m[due[i]] = 1'b1;
                lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            end
            chk("stall_returns", 64'(returns), 64'(grants));
        end
`else
        vecs[0]  = '{C_ST, 32'h100,   DA, 4'd1, 4'd0, 64'h0};
        vecs[1]  = '{C_LD, 32'h100,   '0, 4'd1, 4'd0, 64'h0};
        vecs[2]  = '{C_NO, 32'h0,     '0, 4'd0, 4'd0, 64'h0};
        vecs[3]  = '{C_NO, 32'h0,     '0, 4'd0, 4'd0, 64'h0};
        vecs[4]  = '{C_NO, 32'h0,     '0, 4'd0, 4'd0, 64'h0};
        vecs[5]  = '{C_NO, 32'h0,     '0, 4'd0, 4'd1, DA};
        vecs[6]  = '{C_NO, 32'h0,     '0, 4'd0, 4'd0, 64'h0};
        vecs[7]  = '{C_ST, 32'h0,     D0, 4'd1, 4'd0, 64'h0};
        vecs[8]  = '{C_ST, 32'h8,     D1, 4'd1, 4'd0, 64'h0};
        vecs[9]  = '{C_ST, 32'h10,    D2, 4'd1, 4'd0, 64'h0};
        vecs[10] = '{C_ST, 32'h18,    D3, 4'd1, 4'd0, 64'h0};
        vecs[11] = '{C_LD, 32'h0,     '0, 4'd1, 4'd0, 64'h0};
        vecs[12] = '{C_LD, 32'h8,     '0, 4'd2, 4'd0, 64'h0};
        vecs[13] = '{C_LD, 32'h10,    '0, 4'd3, 4'd0, 64'h0};
        vecs[14] = '{C_LD, 32'h18,    '0, 4'd4, 4'd0, 64'h0};
        vecs[15] = '{C_LD, 32'h107,   '0, 4'd5, 4'd1, D0};
        vecs[16] = '{C_LD, 32'h10100, '0, 4'd1, 4'd2, D1};
        vecs[17] = '{C_NO, 32'h0,     '0, 4'd0, 4'd3, D2};
        vecs[18] = '{C_NO, 32'h0,     '0, 4'd0, 4'd4, D3};
        vecs[19] = '{C_NO, 32'h0,     '0, 4'd0, 4'd5, DA};
        vecs[20] = '{C_NO, 32'h0,     '0, 4'd0, 4'd1, DA};
        vecs[21] = '{2'd3, 32'h100,   '0, 4'd0, 4'd0, 64'h0};
        vecs[22] = '{C_NO, 32'h0,     '0, 4'd0, 4'd0, 64'h0};
        vecs[23] = '{C_NO, 32'h0,     '0, 4'd0, 4'd0, 64'h0};
        vecs[24] = '{C_NO, 32'h0,     '0, 4'd0, 4'd0, 64'h0};
        vecs[25] = '{C_NO, 32'h0,     '0, 4'd0, 4'd0, 64'h0};
        vecs[26] = '{C_ST, 32'h8,     DN, 4'd1, 4'd0, 64'h0};
        vecs[27] = '{C_LD, 32'h8,     '0, 4'd1, 4'd0, 64'h0};
        vecs[28] = '{C_NO, 32'h0,     '0, 4'd0, 4'd0, 64'h0};
        vecs[29] = '{C_NO, 32'h0,     '0, 4'd0, 4'd0, 64'h0};
        vecs[30] = '{C_NO, 32'h0,     '0, 4'd0, 4'd0, 64'h0};
        vecs[31] = '{C_NO, 32'h0,     '0, 4'd0, 4'd1, DN};
        vecs[32] = '{C_NO, 32'h0,     '0, 4'd0, 4'd0, 64'h0};

        for (int i = 0; i < 33; i++) begin
            step(1'b0, 1'b0, vecs[i].cmd, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("vec%0d_resp", i), 64'(s_resp), 64'(vecs[i].resp));
            chk($sformatf("vec%0d_tag", i), 64'(s_tag), 64'(vecs[i].tag));
            chk($sformatf("vec%0d_data", i), s_data, vecs[i].data);
        end

        // Three loads in flight when reset hits: none may return; array survives reset.
        step(1'b0, 1'b0, C_LD, 32'h0, '0);
        chk("rst_fl_resp0", 64'(s_resp), 64'd1);
        step(1'b0, 1'b0, C_LD, 32'h8, '0);
        chk("rst_fl_resp1", 64'(s_resp), 64'd2);
        step(1'b0, 1'b0, C_LD, 32'h10, '0);
        chk("rst_fl_resp2", 64'(s_resp), 64'd3);
        step(1'b1, 1'b0, C_NO, 32'h0, '0);
        chk("rst_fl_tag_r3", 64'(s_tag), 64'd0);
        step(1'b1, 1'b0, C_LD, 32'h0, '0);
        chk("rst_fl_resp_in_rst", 64'(s_resp), 64'd0);
        chk("rst_fl_tag_r4", 64'(s_tag), 64'd0);
        step(1'b0, 1'b0, C_LD, 32'h10, '0);
        chk("post_rst_resp", 64'(s_resp), 64'd1);
        chk("post_rst_tag", 64'(s_tag), 64'd0);
        chk("post_rst_data", s_data, 64'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, C_NO, 32'h0, '0);
            chk("post_rst_quiet", 64'(s_tag), 64'd0);
        end
        step(1'b0, 1'b0, C_NO, 32'h0, '0);
        chk("post_rst_ret_tag", 64'(s_tag), 64'd1);
        chk("post_rst_ret_data", s_data, D2);
        step(1'b0, 1'b0, C_NO, 32'h0, '0);
        chk("post_rst_after", 64'(s_tag), 64'd0);

        // LATENCY=20: exhaust all 15 tags, then reuse tag 1 once it returns.
        for (int k = 0; k < 43; k++) begin
            logic [1:0] c;
            logic [3:0] er;
            logic [3:0] et;
            c  = (k < 16 || k == 20 || k == 21) ? C_LD : C_NO;
            er = (k < 15) ? 4'(k + 1) : ((k == 21) ? 4'd1 : 4'd0);
            et = (k >= 20 && k <= 34) ? 4'(k - 19) : ((k == 41) ? 4'd1 : 4'd0);
            step(1'b0, 1'b1, c, 32'(k * 8), '0);
            chk($sformatf("lat20_k%0d_resp", k), 64'(s_resp), 64'(er));
            chk($sformatf("lat20_k%0d_tag", k), 64'(s_tag), 64'(et));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
